// File: rtl/bus_decoder_n.sv
// rtl/bus_decoder_n.sv - single-master to N-slave bus decoder with unmapped/timeout error reporting
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m_addr_i/m_data_i/m_we_i master request; m_select_i != 0 marks a valid request
//   m_data_o/m_ack_o/m_err_o master response; ack and err are one-cycle pulses
//   s_addr_o/s_data_o/s_sel_o latched request broadcast to every slave
//   s_we_o/s_select_o        per-slave write enable and one-hot select
//   s_data_i/s_ack_i         slave responses, slave k on slice k
//   busy_o                   a transaction is in progress or awaiting request release
//   err_count_o              saturating count of error completions
module bus_decoder_n #(
  parameter int                   ADDR_W     = 32,
  parameter int                   DATA_W     = 32,
  parameter int                   SEL_W      = 4,
  parameter int                   NUM_SLAVES = 8,
  parameter int                   IDX_W      = 3,
  parameter int                   DECODE_LSB = 28,
  parameter int                   TIMEOUT    = 255,
  parameter logic [DATA_W-1:0]    ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_data_i,
  input  logic                         m_we_i,
  input  logic [SEL_W-1:0]             m_select_i,
  output logic [DATA_W-1:0]            m_data_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_data_o,
  output logic [SEL_W-1:0]             s_sel_o,
  output logic [NUM_SLAVES-1:0]        s_we_o,
  output logic [NUM_SLAVES-1:0]        s_select_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  output logic                         busy_o,
  output logic [7:0]                   err_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last timer value before the transaction is declared timed out.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_SLAVES-1:0]   we_q, we_d;
  logic [NUM_SLAVES-1:0]   select_q, select_d;
  logic [15:0]             timer_q, timer_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]        req_idx;
  logic                    req_mapped;
  logic [NUM_SLAVES-1:0]   req_onehot;
  logic                    slv_ack;
  logic [DATA_W-1:0]       slv_data;

  // Decode the incoming request into a one-hot slave vector.
  always_comb begin
    req_idx    = m_addr_i[DECODE_LSB +: IDX_W];
    req_mapped = (32'(req_idx) < NUM_SLAVES);
    req_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_onehot[k] = (req_idx == IDX_W'(k));
    end
  end

  // Only the currently selected slave's ack and data are observed, so
  // acks from any other slave are ignored by construction.
  always_comb begin
    slv_ack  = 1'b0;
    slv_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (select_q[k]) begin
        slv_ack  = s_ack_i[k];
        slv_data = s_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    we_d      = we_q;
    select_d  = select_q;
    timer_d   = timer_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (|m_select_i) begin
          addr_d  = m_addr_i;
          wdata_d = m_data_i;
          sel_d   = m_select_i;
          if (req_mapped) begin
            select_d = req_onehot;
            we_d     = m_we_i ? req_onehot : '0;
            timer_d  = '0;
            state_d  = ST_BUSY;
          end else begin
            select_d = '0;
            we_d     = '0;
            ack_d    = 1'b1;
            err_d    = 1'b1;
            rdata_d  = ERR_DATA;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            state_d  = ST_DONE;
          end
        end
      end

      ST_BUSY: begin
        timer_d = timer_q + 16'd1;
        // A real ack takes priority over a coincident timeout.
        if (slv_ack) begin
          rdata_d  = slv_data;
          ack_d    = 1'b1;
          select_d = '0;
          we_d     = '0;
          state_d  = ST_DONE;
        end else if (timer_q == TO_LAST) begin
          rdata_d  = ERR_DATA;
          ack_d    = 1'b1;
          err_d    = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          select_d = '0;
          we_d     = '0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        // Wait for the master to drop its request so it is not re-issued.
        if (m_select_i == '0) state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        select_d = '0;
        we_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      we_q      <= '0;
      select_q  <= '0;
      timer_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      select_q  <= select_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_data_o    = rdata_q;
  assign m_ack_o     = ack_q;
  assign m_err_o     = err_q;
  assign s_addr_o    = addr_q;
  assign s_data_o    = wdata_q;
  assign s_sel_o     = sel_q;
  assign s_we_o      = we_q;
  assign s_select_o  = select_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_count_o = err_cnt_q;

endmodule
